// File: rtl/pipe_regchain_pkg.sv
// pipe_pkg: shared helpers for the pipe_regchain elastic register chain.
// Contents:
//   clog2_cnt(n) - number of bits needed to hold any count 0..n
//                  (the width of the occupancy counter for n stages).
package pipe_pkg;

  // Smallest w with 2**w > n, never less than 1 bit.
  function automatic int clog2_cnt(input int n);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << w) <= n) begin
        w = w + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/pipe_regchain_slot.sv
// pipe_slot: one stage of the pipe_regchain elastic chain.
// Ports:
//   clk, reset  - rising-edge clock, asynchronous active-high reset
//   flush       - synchronous kill of this stage's entry (beats any load)
//   up_valid    - upstream stage is handing over an entry this cycle
//   up_data     - payload offered by upstream
//   dn_ready    - downstream will take this stage's entry this cycle
//   valid, data - stage contents
//   acc         - stage loads on the next edge (empty, or draining downstream)
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CLEAR_DATA = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             acc
);

  // An empty stage always accepts; a full one only when its entry leaves.
  assign acc = ~valid | dn_ready;

  // Flush outranks loading. The payload follows the upstream register
  // whenever the stage accepts, even when no valid entry comes with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      if (CLEAR_DATA != 0) begin
        data <= '0;
      end
    end else if (acc) begin
      valid <= up_valid;
      data  <= up_data;
    end
  end

endmodule

// File: rtl/pipe_regchain.sv
// pipe_regchain: STAGES-deep elastic pipeline register with valid/ready
// flow control, bubble collapsing and synchronous flush.
// Ports:
//   clk, reset           - rising-edge clock, asynchronous active-high reset
//   flush                - kill all in-flight entries on the next edge
//   in_valid/in_ready    - upstream handshake; in_ready ignores in_valid
//   in_data              - payload in (WIDTH bits)
//   out_valid/out_ready  - downstream handshake on the last stage
//   out_data             - last stage payload register
//   occupancy            - number of stages currently holding an entry
module pipe_regchain
  import pipe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STAGES     = 3,
  parameter int CLEAR_DATA = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [clog2_cnt(STAGES)-1:0]   occupancy
);

  localparam int OCC_W = clog2_cnt(STAGES);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] acc;
  logic [STAGES-1:0] dn_ready;
  logic [STAGES-1:0] up_valid;
  logic [WIDTH-1:0]  d    [STAGES];
  logic [WIDTH-1:0]  up_d [STAGES];

  generate
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      // Stage i may drain when out_ready is high or any stage from i+1 up
      // to the output holds a bubble. This is acc[i+1] unrolled, so the
      // ready chain is written straight from the valid bits.
      if (i == STAGES - 1) begin : g_last
        assign dn_ready[i] = out_ready;
      end else begin : g_mid
        assign dn_ready[i] = out_ready | ~(&v[STAGES-1:i+1]);
      end

      if (i == 0) begin : g_first
        assign up_valid[i] = in_valid & acc[i];
        assign up_d[i]     = in_data;
      end else begin : g_inner
        assign up_valid[i] = v[i-1] & acc[i];
        assign up_d[i]     = d[i-1];
      end

      pipe_slot #(
        .WIDTH      (WIDTH),
        .CLEAR_DATA (CLEAR_DATA)
      ) u_slot (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .up_valid (up_valid[i]),
        .up_data  (up_d[i]),
        .dn_ready (dn_ready[i]),
        .valid    (v[i]),
        .data     (d[i]),
        .acc      (acc[i])
      );
    end
  endgenerate

  assign in_ready  = acc[0];
  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

  // Occupancy is a plain popcount of the stage valid bits.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(v[i]);
    end
  end

endmodule

// File: tb/tb_pipe_regchain.sv
// tb_pipe_regchain: directed bench for pipe_regchain. A 4-stage chain and a
// 1-stage chain share one stimulus stream. Each directed vector states the
// in_ready it expects from each chain; entries expected to be accepted go
// into a per-chain queue, and a monitor per chain pops and compares every
// output transfer.
module tb_pipe_regchain;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] occupancy;

  logic       in_ready1;
  logic       out_valid1;
  logic [7:0] out_data1;
  logic [0:0] occupancy1;

  int total;
  int bad;

  logic [7:0] exp4 [$];
  logic [7:0] exp1 [$];
  logic [7:0] e4;
  logic [7:0] e1;

  pipe_regchain #(.WIDTH(8), .STAGES(4), .CLEAR_DATA(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  pipe_regchain #(.WIDTH(8), .STAGES(1), .CLEAR_DATA(0)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_data  (out_data1),
    .occupancy (occupancy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, queue the entries each chain should accept,
  // check both in_ready values, then advance to just after the next edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic ordy,
                               input logic fl, input logic er4, input logic er1);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    if (v && er4 && !fl) exp4.push_back(d);
    if (v && er1 && !fl) exp1.push_back(d);
    #1;
    checkOutput("in_ready_s4", 32'(in_ready), 32'(er4));
    checkOutput("in_ready_s1", 32'(in_ready1), 32'(er1));
    @(posedge clk);
    #1;
    if (fl) begin
      exp4.delete();
      exp1.delete();
    end
  endtask

  // Output monitors: an output handshake seen mid-cycle completes on the next edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp4.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL out_s4_unexpected: got 0x%0h expected no output", out_data);
      end else begin
        e4 = exp4.pop_front();
        checkOutput("out_data_s4", 32'(out_data), 32'(e4));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid1 && out_ready) begin
      if (exp1.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL out_s1_unexpected: got 0x%0h expected no output", out_data1);
      end else begin
        e1 = exp1.pop_front();
        checkOutput("out_data_s1", 32'(out_data1), 32'(e1));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid_s1", 32'(out_valid1), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Streaming: 0x01 reaches out_data three edges after it was accepted.
    $display("[TB] stream 0x01..0x08");
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 8'(k), 1'b1, 1'b0, 1'b1, 1'b1);
      if (k == 4) begin
        checkOutput("lat_out_valid", 32'(out_valid), 32'd1);
        checkOutput("lat_out_data", 32'(out_data), 32'h01);
        checkOutput("lat_occupancy", 32'(occupancy), 32'd4);
      end
    end
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("stream_drained", 32'(occupancy), 32'd0);

    // Backpressure until full, then release.
    $display("[TB] fill under backpressure");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 8'hA0 + 8'(k), 1'b0, 1'b0, (k < 4), (k == 0));
    end
    checkOutput("full_occupancy", 32'(occupancy), 32'd4);
    checkOutput("full_out_data", 32'(out_data), 32'hA0);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("full_drained", 32'(occupancy), 32'd0);

    // A gap between two entries closes while the output is stalled.
    $display("[TB] bubble collapse");
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("bubble_occupancy", 32'(occupancy), 32'd2);
    checkOutput("bubble_out_data", 32'(out_data), 32'h11);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("bubble_back2back_valid", 32'(out_valid), 32'd1);
    checkOutput("bubble_back2back_data", 32'(out_data), 32'h22);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("bubble_drained", 32'(occupancy), 32'd0);

    // Flush a full chain while the head is consumed and 0x55 is offered.
    $display("[TB] flush");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 8'hB0 + 8'(k), 1'b0, 1'b0, 1'b1, (k == 0));
    end
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("flush_occupancy", 32'(occupancy), 32'd0);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_data_kept", 32'(out_data), 32'hB0);
    checkOutput("flush_out_valid_s1", 32'(out_valid1), 32'd0);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);

    // Push and pop together on a full chain.
    $display("[TB] full pop+push");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 8'hD0 + 8'(k), 1'b0, 1'b0, 1'b1, (k == 0));
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_out_data", 32'(out_data), 32'hD0);
    applyStimulus(1'b1, 8'hD4, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("pp_occupancy_1", 32'(occupancy), 32'd4);
    checkOutput("pp_out_data_1", 32'(out_data), 32'hD1);
    checkOutput("pp_out_data_s1", 32'(out_data1), 32'hD4);
    applyStimulus(1'b1, 8'hD5, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("pp_occupancy_2", 32'(occupancy), 32'd4);
    checkOutput("pp_out_data_2", 32'(out_data), 32'hD2);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("pp_drained", 32'(occupancy), 32'd0);

    // Asynchronous reset in the middle of a stream, between clock edges.
    $display("[TB] async reset mid-stream");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'hE0 + 8'(k), 1'b1, 1'b0, 1'b1, 1'b1);
    end
    #1;
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_out_data", 32'(out_data), 32'd0);
    checkOutput("arst_occupancy", 32'(occupancy), 32'd0);
    checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("arst_out_valid_s1", 32'(out_valid1), 32'd0);
    checkOutput("arst_out_data_s1", 32'(out_data1), 32'd0);
    exp4.delete();
    exp1.delete();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single-stage chain under toggling out_ready: in_ready follows each pop.
    $display("[TB] single stage toggle");
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, 8'hF0 + 8'(c), (c % 2 == 1), 1'b0, (c != 4),
                    (c == 0) || (c % 2 == 1));
    end
    checkOutput("s1_occupancy", 32'(occupancy1), 32'd1);
    repeat (5) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("end_occupancy_s4", 32'(occupancy), 32'd0);
    checkOutput("end_occupancy_s1", 32'(occupancy1), 32'd0);
    checkOutput("end_pending_s4", 32'(exp4.size()), 32'd0);
    checkOutput("end_pending_s1", 32'(exp1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
